assay_lane_sequencer: RTL and testbench

- Clocked controller for a parametrised synthetic assay. N_CH sample lanes share one heater, one mixer and one detector.
- For each enabled lane, in ascending index order, it runs the protocol LOAD -> HEAT -> MIX -> DETECT -> REPORT. Once all enabled lanes are done it runs FLUSH.
- This is the sequential successor to the fixed chamber/filter/heater/mixer/detector netlists: lane count, step durations and lane selection are all run-time or parameter configurable.
- Sits between the host and the fluidic actuator drivers.

---
 rtl/assay_lane_sequencer_if.sv | 44 ++++
 rtl/assay_lane_sequencer.sv | 164 ++++++++++++++++
 tb/tb_assay_lane_sequencer.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/assay_lane_sequencer_if.sv
// Host, detector, result and actuator signals of the assay lane sequencer.
// The sequencer connects through the slave modport; whoever drives it uses master.
interface assay_lane_sequencer_if #(
    parameter int N_CH   = 4,
    parameter int CNT_W  = 8,
    parameter int DATA_W = 12
);
    localparam int LW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic              start;
    logic [N_CH-1:0]   lane_mask;
    logic [CNT_W-1:0]  load_cyc;
    logic [CNT_W-1:0]  heat_cyc;
    logic [CNT_W-1:0]  mix_cyc;
    logic              abort;
    logic [DATA_W-1:0] det_data;
    logic              det_valid;
    logic              res_ready;

    logic [N_CH-1:0]   valve_in;
    logic              heater_en;
    logic              mixer_en;
    logic              det_req;
    logic              flush_en;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic [LW-1:0]     res_lane;
    logic              busy;
    logic              done;

    modport master (
        output start, lane_mask, load_cyc, heat_cyc, mix_cyc, abort,
               det_data, det_valid, res_ready,
        input  valve_in, heater_en, mixer_en, det_req, flush_en,
               res_valid, res_data, res_lane, busy, done
    );

    modport slave (
        input  start, lane_mask, load_cyc, heat_cyc, mix_cyc, abort,
               det_data, det_valid, res_ready,
        output valve_in, heater_en, mixer_en, det_req, flush_en,
               res_valid, res_data, res_lane, busy, done
    );
endinterface

// File: rtl/assay_lane_sequencer.sv
// Runs LOAD/HEAT/MIX/DETECT/REPORT for each selected lane in ascending order,
// then FLUSH; all outputs are registered from the next-state decode.
module assay_lane_sequencer #(
    parameter int N_CH      = 4,
    parameter int CNT_W     = 8,
    parameter int DATA_W    = 12,
    parameter int FLUSH_CYC = 4
) (
    input logic                   clk,
    input logic                   rst,
    assay_lane_sequencer_if.slave bus
);
    localparam int LW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYC - 1);

    typedef enum logic [2:0] {IDLE, LOAD, HEAT, MIX, DETECT, REPORT, FLUSH} state_t;

    state_t            state, nstate;
    logic [CNT_W-1:0]  cnt, ncnt;
    logic [LW-1:0]     lane, nlane;
    logic              ndone;
    logic              capture;
    logic [N_CH-1:0]   mask_q;
    logic [CNT_W-1:0]  load_q, heat_q, mix_q;
    logic [LW:0]       first_hit, next_hit;

    logic [N_CH-1:0]   valve_q;
    logic              heater_q, mixer_q, det_req_q, flush_q, res_valid_q, busy_q, done_q;
    logic [DATA_W-1:0] res_data_q;
    logic [LW-1:0]     res_lane_q;

    // Counter holds the remaining cycles minus one; a zero duration still gets one cycle.
    function automatic logic [CNT_W-1:0] last_cyc(input logic [CNT_W-1:0] n);
        return (n == '0) ? '0 : n - CNT_W'(1);
    endfunction

    // Returns {found, index} of the lowest set mask bit at or above 'from'.
    function automatic logic [LW:0] find_lane(input logic [N_CH-1:0] m, input int from);
        logic [LW:0] r;
        r = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (m[i] && i >= from) r = {1'b1, LW'(i)};
        end
        return r;
    endfunction

    assign first_hit = find_lane(bus.lane_mask, 0);
    assign next_hit  = find_lane(mask_q, int'(lane) + 1);

    always_comb begin
        nstate  = state;
        ncnt    = cnt;
        nlane   = lane;
        ndone   = 1'b0;
        capture = 1'b0;
        case (state)
            IDLE: if (bus.start) begin
                capture = 1'b1;
                if (first_hit[LW]) begin
                    nstate = LOAD;
                    nlane  = first_hit[LW-1:0];
                    ncnt   = last_cyc(bus.load_cyc);
                end else begin
                    ndone = 1'b1;
                end
            end
            LOAD: if (cnt == '0) begin
                nstate = HEAT;
                ncnt   = last_cyc(heat_q);
            end else ncnt = cnt - CNT_W'(1);
            HEAT: if (cnt == '0) begin
                nstate = MIX;
                ncnt   = last_cyc(mix_q);
            end else ncnt = cnt - CNT_W'(1);
            MIX: if (cnt == '0) nstate = DETECT;
                 else ncnt = cnt - CNT_W'(1);
            DETECT: if (bus.det_valid) nstate = REPORT;
            REPORT: if (bus.res_ready) begin
                if (next_hit[LW]) begin
                    nstate = LOAD;
                    nlane  = next_hit[LW-1:0];
                    ncnt   = last_cyc(load_q);
                end else begin
                    nstate = FLUSH;
                    ncnt   = FLUSH_LAST;
                end
            end
            FLUSH: if (cnt == '0) begin
                nstate = IDLE;
                ndone  = 1'b1;
            end else ncnt = cnt - CNT_W'(1);
            default: nstate = IDLE;
        endcase
        // Abort overrides any transfer that completes in the same cycle.
        if (bus.abort && state != IDLE && state != FLUSH) begin
            nstate = FLUSH;
            ncnt   = FLUSH_LAST;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            lane  <= '0;
        end else begin
            state <= nstate;
            cnt   <= ncnt;
            lane  <= nlane;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            mask_q <= bus.lane_mask;
            load_q <= bus.load_cyc;
            heat_q <= bus.heat_cyc;
            mix_q  <= bus.mix_cyc;
        end
    end

    // Output registers: decoded from the state being entered, so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            valve_q     <= '0;
            heater_q    <= 1'b0;
            mixer_q     <= 1'b0;
            det_req_q   <= 1'b0;
            flush_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_lane_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            valve_q     <= (nstate == LOAD) ? (N_CH'(1) << nlane) : '0;
            heater_q    <= (nstate == HEAT);
            mixer_q     <= (nstate == MIX);
            det_req_q   <= (nstate == DETECT);
            flush_q     <= (nstate == FLUSH);
            res_valid_q <= (nstate == REPORT);
            busy_q      <= (nstate != IDLE);
            done_q      <= ndone;
            if (nstate == REPORT) begin
                res_data_q <= (state == DETECT) ? bus.det_data : res_data_q;
                res_lane_q <= (state == DETECT) ? lane : res_lane_q;
            end else begin
                res_data_q <= '0;
                res_lane_q <= '0;
            end
        end
    end

    assign bus.valve_in  = valve_q;
    assign bus.heater_en = heater_q;
    assign bus.mixer_en  = mixer_q;
    assign bus.det_req   = det_req_q;
    assign bus.flush_en  = flush_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_lane  = res_lane_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_assay_lane_sequencer.sv
// Bench for assay_lane_sequencer: builds the expected per-cycle output trace of
// each run from the protocol rules, drives matching stimulus and compares.
module tb_assay_lane_sequencer;
    localparam int N_CH      = 4;
    localparam int CNT_W     = 8;
    localparam int DATA_W    = 12;
    localparam int FLUSH_CYC = 4;
    localparam int LW        = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    assay_lane_sequencer_if #(.N_CH(N_CH), .CNT_W(CNT_W), .DATA_W(DATA_W)) bus ();

    assay_lane_sequencer #(.N_CH(N_CH), .CNT_W(CNT_W), .DATA_W(DATA_W), .FLUSH_CYC(FLUSH_CYC))
        dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct packed {
        logic [N_CH-1:0]   valve;
        logic              heater, mixer, det_req, flush, res_valid;
        logic [DATA_W-1:0] res_data;
        logic [LW-1:0]     res_lane;
        logic              busy, done;
    } out_t;

    typedef struct packed {
        logic              start;
        logic [N_CH-1:0]   mask;
        logic              abort, det_valid;
        logic [DATA_W-1:0] det_data;
        logic              res_ready;
    } drv_t;

    out_t exp_q[$];
    out_t act_q[$];
    drv_t drv_q[$];
    int   det_wait[N_CH];
    int   rep_stall[N_CH];
    logic [DATA_W-1:0] det_val[N_CH];
    int   start_pct = 30;
    int   tests_run = 0;
    int   tests_failed = 0;

    function automatic out_t sample();
        out_t s;
        s.valve = bus.valve_in;   s.heater = bus.heater_en; s.mixer = bus.mixer_en;
        s.det_req = bus.det_req;  s.flush = bus.flush_en;   s.res_valid = bus.res_valid;
        s.res_data = bus.res_data; s.res_lane = bus.res_lane;
        s.busy = bus.busy;        s.done = bus.done;
        return s;
    endfunction

    function automatic int max1(input int n);
        return (n < 1) ? 1 : n;
    endfunction

    // Noise on inputs that must be ignored in the current step; a start is only
    // scattered into cycles where the sequencer is busy.
    function automatic drv_t rand_drv(input bit active);
        drv_t d;
        d.start     = active && ($urandom_range(0, 99) < start_pct);
        d.mask      = N_CH'($urandom);
        d.abort     = 1'b0;
        d.det_valid = 1'($urandom_range(0, 1));
        d.det_data  = DATA_W'($urandom);
        d.res_ready = 1'($urandom_range(0, 1));
        return d;
    endfunction

    task automatic push(input out_t o, input drv_t d);
        exp_q.push_back(o);
        drv_q.push_back(d);
    endtask

    // Reference model: protocol steps laid out as cycle segments.
    task automatic build_plan(input logic [N_CH-1:0] m, input int l, h, x, input int abort_at);
        out_t o;
        drv_t d;
        int   fstart;
        exp_q.delete();
        drv_q.delete();
        for (int i = 0; i < N_CH; i++) begin
            if (m[i]) begin
                o = '0; o.busy = 1'b1; o.valve = N_CH'(1) << i;
                for (int c = 0; c < max1(l); c++) push(o, rand_drv(1'b1));
                o = '0; o.busy = 1'b1; o.heater = 1'b1;
                for (int c = 0; c < max1(h); c++) push(o, rand_drv(1'b1));
                o = '0; o.busy = 1'b1; o.mixer = 1'b1;
                for (int c = 0; c < max1(x); c++) push(o, rand_drv(1'b1));
                o = '0; o.busy = 1'b1; o.det_req = 1'b1;
                for (int c = 0; c <= det_wait[i]; c++) begin
                    d = rand_drv(1'b1);
                    d.det_valid = (c == det_wait[i]);
                    if (d.det_valid) d.det_data = det_val[i];
                    push(o, d);
                end
                o = '0; o.busy = 1'b1; o.res_valid = 1'b1;
                o.res_data = det_val[i]; o.res_lane = LW'(i);
                for (int c = 0; c <= rep_stall[i]; c++) begin
                    d = rand_drv(1'b1);
                    d.res_ready = (c == rep_stall[i]);
                    push(o, d);
                end
            end
        end
        fstart = exp_q.size();
        if (abort_at >= 0 && abort_at < fstart) begin
            while (exp_q.size() > abort_at + 1) begin
                void'(exp_q.pop_back());
                void'(drv_q.pop_back());
            end
            d = drv_q[abort_at]; d.abort = 1'b1; drv_q[abort_at] = d;
        end
        if (m != '0) begin
            o = '0; o.busy = 1'b1; o.flush = 1'b1;
            for (int c = 0; c < FLUSH_CYC; c++) begin
                d = rand_drv(1'b1); d.abort = 1'($urandom_range(0, 1));
                push(o, d);
            end
        end
        o = '0; o.done = 1'b1;
        d = rand_drv(1'b0); d.abort = 1'($urandom_range(0, 1));
        push(o, d);
        o = '0;
        push(o, rand_drv(1'b0));
        if (abort_at >= fstart && abort_at < drv_q.size()) begin
            d = drv_q[abort_at]; d.abort = 1'b1; drv_q[abort_at] = d;
        end
    endtask

    task automatic quiet();
        bus.start = 1'b0; bus.abort = 1'b0; bus.det_valid = 1'b0;
        bus.res_ready = 1'b0; bus.det_data = '0;
    endtask

    task automatic apply(input drv_t d);
        bus.start = d.start; bus.lane_mask = d.mask; bus.abort = d.abort;
        bus.det_valid = d.det_valid; bus.det_data = d.det_data; bus.res_ready = d.res_ready;
    endtask

    task automatic start_run(input logic [N_CH-1:0] m, input int l, h, x);
        @(negedge clk);
        quiet();
        bus.start = 1'b1; bus.lane_mask = m;
        bus.load_cyc = CNT_W'(l); bus.heat_cyc = CNT_W'(h); bus.mix_cyc = CNT_W'(x);
    endtask

    // Drives the planned stimulus and records what the DUT shows each cycle.
    task automatic execute(input logic [N_CH-1:0] m, input int l, h, x);
        start_run(m, l, h, x);
        act_q.delete();
        for (int k = 0; k < drv_q.size(); k++) begin
            @(negedge clk);
            act_q.push_back(sample());
            apply(drv_q[k]);
        end
        @(negedge clk);
        quiet();
    endtask

    task automatic lanes_default();
        for (int i = 0; i < N_CH; i++) begin
            det_wait[i] = 0; rep_stall[i] = 0; det_val[i] = DATA_W'($urandom);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        quiet();
        bus.lane_mask = '0; bus.load_cyc = '0; bus.heat_cyc = '0; bus.mix_cyc = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (sample() !== out_t'(0)) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h expected 0", sample());
        end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (sample() !== out_t'(0)) begin
            tests_failed++;
            $display("FAIL reset_idle: got %h expected 0", sample());
        end
    endtask

    task automatic test_basic();
        lanes_default();
        det_wait[0] = 1; det_wait[2] = 1;
        det_val[0] = 12'h123; det_val[2] = 12'h456;
        build_plan(4'b0101, 3, 5, 2, -1);
        execute(4'b0101, 3, 5, 2);
        for (int k = 0; k < exp_q.size(); k++) begin
            tests_run++;
            if (act_q[k] !== exp_q[k]) begin
                tests_failed++;
                $display("FAIL basic cyc%0d: got %h expected %h", k, act_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_zero_durations();
        int first_rv;
        lanes_default();
        build_plan(4'b0001, 0, 0, 0, -1);
        execute(4'b0001, 0, 0, 0);
        first_rv = -1;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (first_rv < 0 && act_q[k].res_valid) first_rv = k + 1;
            tests_run++;
            if (act_q[k] !== exp_q[k]) begin
                tests_failed++;
                $display("FAIL zero_dur cyc%0d: got %h expected %h", k, act_q[k], exp_q[k]);
            end
        end
        tests_run++;
        if (first_rv !== 5) begin
            tests_failed++;
            $display("FAIL zero_dur_latency: got %0d cycles expected 5", first_rv);
        end
    endtask

    task automatic test_backpressure();
        int held;
        lanes_default();
        rep_stall[0] = 10; rep_stall[1] = 3;
        build_plan(4'b0011, 1, 2, 1, -1);
        execute(4'b0011, 1, 2, 1);
        held = 0;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (act_q[k].res_valid && act_q[k].res_lane == 0 && act_q[k].res_data == det_val[0])
                held++;
            tests_run++;
            if (act_q[k] !== exp_q[k]) begin
                tests_failed++;
                $display("FAIL backpressure cyc%0d: got %h expected %h", k, act_q[k], exp_q[k]);
            end
        end
        tests_run++;
        if (held !== 11) begin
            tests_failed++;
            $display("FAIL backpressure_hold: got %0d cycles expected 11", held);
        end
    endtask

    task automatic test_abort();
        int dones, lost;
        lanes_default();
        build_plan(4'b0011, 2, 4, 2, 13);
        execute(4'b0011, 2, 4, 2);
        dones = 0; lost = 0;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (act_q[k].done) dones++;
            if (act_q[k].res_valid && act_q[k].res_lane == 1) lost++;
            tests_run++;
            if (act_q[k] !== exp_q[k]) begin
                tests_failed++;
                $display("FAIL abort cyc%0d: got %h expected %h", k, act_q[k], exp_q[k]);
            end
        end
        tests_run++;
        if (dones !== 1 || lost !== 0) begin
            tests_failed++;
            $display("FAIL abort_summary: got done=%0d lane1=%0d expected done=1 lane1=0", dones, lost);
        end
    endtask

    task automatic test_zero_mask();
        lanes_default();
        build_plan(4'b0000, 3, 3, 3, -1);
        execute(4'b0000, 3, 3, 3);
        for (int k = 0; k < exp_q.size(); k++) begin
            tests_run++;
            if (act_q[k] !== exp_q[k]) begin
                tests_failed++;
                $display("FAIL zero_mask cyc%0d: got %h expected %h", k, act_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        start_pct = 100;
        lanes_default();
        det_wait[1] = 2; rep_stall[2] = 2;
        build_plan(4'b0110, 2, 1, 3, -1);
        execute(4'b0110, 2, 1, 3);
        for (int k = 0; k < exp_q.size(); k++) begin
            tests_run++;
            if (act_q[k] !== exp_q[k]) begin
                tests_failed++;
                $display("FAIL busy_start cyc%0d: got %h expected %h", k, act_q[k], exp_q[k]);
            end
        end
        start_pct = 30;
    endtask

    task automatic test_rst_mid_run();
        start_pct = 0;
        lanes_default();
        build_plan(4'b0001, 2, 2, 3, -1);
        start_run(4'b0001, 2, 2, 3);
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            tests_run++;
            if (sample() !== exp_q[k]) begin
                tests_failed++;
                $display("FAIL rst_pre cyc%0d: got %h expected %h", k, sample(), exp_q[k]);
            end
            apply(drv_q[k]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        quiet();
        for (int k = 0; k < 2; k++) begin
            tests_run++;
            if (sample() !== out_t'(0)) begin
                tests_failed++;
                $display("FAIL rst_mid cyc%0d: got %h expected 0", k, sample());
            end
            @(negedge clk);
        end
        start_pct = 30;
        lanes_default();
        build_plan(4'b1000, 1, 2, 1, -1);
        execute(4'b1000, 1, 2, 1);
        for (int k = 0; k < exp_q.size(); k++) begin
            tests_run++;
            if (act_q[k] !== exp_q[k]) begin
                tests_failed++;
                $display("FAIL rst_rerun cyc%0d: got %h expected %h", k, act_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [N_CH-1:0] m;
        int l, h, x, ab;
        for (int r = 0; r < 10; r++) begin
            m = N_CH'($urandom);
            l = $urandom_range(0, 5); h = $urandom_range(0, 5); x = $urandom_range(0, 5);
            for (int i = 0; i < N_CH; i++) begin
                det_wait[i] = $urandom_range(0, 3);
                rep_stall[i] = $urandom_range(0, 3);
                det_val[i] = DATA_W'($urandom);
            end
            ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 50)) : -1;
            build_plan(m, l, h, x, ab);
            execute(m, l, h, x);
            for (int k = 0; k < exp_q.size(); k++) begin
                tests_run++;
                if (act_q[k] !== exp_q[k]) begin
                    tests_failed++;
                    $display("FAIL random run%0d cyc%0d: got %h expected %h", r, k, act_q[k], exp_q[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_durations();
        test_backpressure();
        test_abort();
        test_zero_mask();
        test_start_while_busy();
        test_rst_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
